// File: rtl/jtag_uart_ctrl_pkg.sv
// Shared types and register map for the jtag_uart Avalon-MM master.
package jtag_uart_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, CTL_RD, DAT_WR, DAT_RD} state_t;

  localparam logic ADDR_DATA  = 1'b0;
  localparam logic ADDR_CTRL  = 1'b1;
  localparam int   RVALID_BIT = 15;
  localparam int   WSPACE_MSB = 31;
  localparam int   WSPACE_LSB = 16;
endpackage

// File: rtl/jtag_uart_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; rr_ptr remembers the last committed winner.
module rr_arb2 (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic [1:0] req,
  input  logic       take,
  output logic       any,
  output logic       winner
);
  logic rr_ptr;

  assign any = |req;

  always_comb begin
    winner = 1'b0;
    case (req)
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~rr_ptr;
      default: winner = 1'b0;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset)  rr_ptr <= 1'b0;
    else if (take)    rr_ptr <= winner;
  end
endmodule

// File: rtl/jtag_uart_ctrl.sv
// Avalon-MM master for jtag_uart: credit-gated two-stream TX into DATA, periodic RX polling.
module jtag_uart_ctrl #(
  parameter int POLL_INTERVAL = 256,
  parameter int CREDIT_W      = 16
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [7:0]  tx0_data,
  input  logic        tx0_valid,
  output logic        tx0_ready,
  input  logic [7:0]  tx1_data,
  input  logic        tx1_valid,
  output logic        tx1_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        avm_chipselect,
  output logic        avm_address,
  output logic        avm_read_n,
  input  logic [31:0] avm_readdata,
  output logic        avm_write_n,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest
);
  import jtag_uart_ctrl_pkg::*;

  localparam int PW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_INTERVAL - 1);
  localparam logic [31:0] CRED_MAX =
    (CREDIT_W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << CREDIT_W) - 32'd1);

  state_t              state, state_nx;
  logic [CREDIT_W-1:0] credit, wspace_sat;
  logic [PW-1:0]       poll_cnt;
  logic [31:0]         wspace;
  logic [1:0]          req;
  logic                any_req, winner, take, poll_due, wr_who;
  logic                unused_rd;

  // A requester whose ready is pulsing this cycle still shows its old byte; mask it.
  assign req      = {tx1_valid & ~tx1_ready, tx0_valid & ~tx0_ready};
  assign poll_due = (poll_cnt == POLL_LAST) & ~rx_valid;
  assign take     = (state == IDLE) & ~poll_due & any_req & (credit != '0);

  assign wspace     = 32'(avm_readdata[WSPACE_MSB:WSPACE_LSB]);
  assign wspace_sat = (wspace > CRED_MAX) ? CRED_MAX[CREDIT_W-1:0] : wspace[CREDIT_W-1:0];
  assign unused_rd  = ^avm_readdata[14:8];

  rr_arb2 u_arb (
    .clk_clk    (clk_clk),
    .reset_reset(reset_reset),
    .req        (req),
    .take       (take),
    .any        (any_req),
    .winner     (winner)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (poll_due)     state_nx = DAT_RD;
        else if (any_req) state_nx = (credit != '0) ? DAT_WR : CTL_RD;
      end
      default: if (!avm_waitrequest) state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state          <= IDLE;
      credit         <= '0;
      poll_cnt       <= '0;
      wr_who         <= 1'b0;
      tx0_ready      <= 1'b0;
      tx1_ready      <= 1'b0;
      rx_valid       <= 1'b0;
      rx_data        <= 8'h00;
      avm_chipselect <= 1'b0;
      avm_address    <= ADDR_DATA;
      avm_read_n     <= 1'b1;
      avm_write_n    <= 1'b1;
      avm_writedata  <= 32'h0;
    end else begin
      state     <= state_nx;
      tx0_ready <= 1'b0;
      tx1_ready <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (poll_due)                  poll_cnt <= '0;
          else if (poll_cnt != POLL_LAST) poll_cnt <= poll_cnt + PW'(1);
          case (state_nx)
            DAT_RD: begin
              avm_chipselect <= 1'b1;
              avm_address    <= ADDR_DATA;
              avm_read_n     <= 1'b0;
            end
            CTL_RD: begin
              avm_chipselect <= 1'b1;
              avm_address    <= ADDR_CTRL;
              avm_read_n     <= 1'b0;
            end
            DAT_WR: begin
              // writedata doubles as the latched byte for the whole command
              avm_chipselect <= 1'b1;
              avm_address    <= ADDR_DATA;
              avm_write_n    <= 1'b0;
              avm_writedata  <= {24'h0, winner ? tx1_data : tx0_data};
              wr_who         <= winner;
            end
            default: ;
          endcase
        end
        default: begin
          if (!avm_waitrequest) begin
            avm_chipselect <= 1'b0;
            avm_read_n     <= 1'b1;
            avm_write_n    <= 1'b1;
            case (state)
              CTL_RD: credit <= wspace_sat;
              DAT_WR: begin
                credit    <= credit - CREDIT_W'(1);
                tx0_ready <= ~wr_who;
                tx1_ready <= wr_who;
              end
              DAT_RD: if (avm_readdata[RVALID_BIT]) begin
                rx_data  <= avm_readdata[7:0];
                rx_valid <= 1'b1;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_jtag_uart_ctrl.sv
// Directed bench: scripted requesters, reactive Avalon slave, immediate-assert checks.
module tb_jtag_uart_ctrl;
  logic        clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic [7:0]  tx0_data = 8'h00, tx1_data = 8'h00;
  logic        tx0_valid = 1'b0, tx1_valid = 1'b0;
  logic        tx0_ready, tx1_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        avm_chipselect, avm_address, avm_read_n, avm_write_n;
  logic [31:0] avm_readdata, avm_writedata;
  logic        avm_waitrequest = 1'b0;

  logic [31:0] ctl_val = 32'h0040_0000;
  logic [31:0] dat_val = 32'h0;

  logic [7:0] tx0_q[$], tx1_q[$], wr_q[$], wr_ctl_q[$];
  logic       rdy_q[$];
  int ctl_cnt = 0, drd_cnt = 0;
  int checks = 0, passes = 0, fails = 0;

  assign avm_readdata = avm_address ? ctl_val : dat_val;

  jtag_uart_ctrl #(.POLL_INTERVAL(4), .CREDIT_W(16)) dut (
    .clk_clk(clk), .reset_reset(reset_reset),
    .tx0_data(tx0_data), .tx0_valid(tx0_valid), .tx0_ready(tx0_ready),
    .tx1_data(tx1_data), .tx1_valid(tx1_valid), .tx1_ready(tx1_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .avm_chipselect(avm_chipselect), .avm_address(avm_address),
    .avm_read_n(avm_read_n), .avm_readdata(avm_readdata),
    .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic feed();
    tx0_valid = (tx0_q.size() != 0);
    tx0_data  = tx0_valid ? tx0_q[0] : 8'h00;
    tx1_valid = (tx1_q.size() != 0);
    tx1_data  = tx1_valid ? tx1_q[0] : 8'h00;
  endtask

  // Record the command completing at the coming edge, clock, then retire accepted bytes.
  task automatic step();
    feed();
    if (!reset_reset && avm_chipselect && !avm_waitrequest) begin
      if (!avm_write_n) begin
        wr_q.push_back(avm_writedata[7:0]);
        wr_ctl_q.push_back(8'(ctl_cnt));
      end
      if (!avm_read_n) begin
        if (avm_address) ctl_cnt++;
        else             drd_cnt++;
      end
    end
    @(posedge clk);
    #1;
    if (tx0_ready) begin rdy_q.push_back(1'b0); if (tx0_q.size() != 0) void'(tx0_q.pop_front()); end
    if (tx1_ready) begin rdy_q.push_back(1'b1); if (tx1_q.size() != 0) void'(tx1_q.pop_front()); end
    feed();
  endtask

  task automatic clear_logs();
    wr_q.delete(); wr_ctl_q.delete(); rdy_q.delete();
    ctl_cnt = 0; drd_cnt = 0;
  endtask

  task automatic wait_rdy(input string tag, input int n);
    for (int i = 0; i < 400 && rdy_q.size() < n; i++) step();
    chk(tag, rdy_q.size(), n);
  endtask

  function automatic logic [31:0] wr_pack(input logic sel_ctl);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < wr_q.size(); i++)
      v = {v[23:0], sel_ctl ? wr_ctl_q[i] : wr_q[i]};
    return v;
  endfunction

  function automatic logic [31:0] rdy_pack();
    logic [31:0] v = 32'h0;
    for (int i = 0; i < rdy_q.size(); i++) v = {v[30:0], rdy_q[i]};
    return v;
  endfunction

  initial begin
    bit found;
    #1;
    step(); step();
    chk("rst_cs", avm_chipselect, 1'b0);
    chk("rst_rd_n", avm_read_n, 1'b1);
    chk("rst_wr_n", avm_write_n, 1'b1);
    chk("rst_addr", avm_address, 1'b0);
    chk("rst_wdata", avm_writedata, 32'h0);
    chk("rst_rdy", {tx1_ready, tx0_ready}, 2'b00);
    chk("rst_rx", {rx_valid, rx_data}, 9'h000);
    chk("rst_credit", 32'(dut.credit), 32'd0);

    // First poll: four idle cycles, then DAT_RD on the data register.
    reset_reset = 1'b0;
    step(); step(); step();
    chk("poll_early", avm_chipselect, 1'b0);
    step();
    chk("poll_cmd", {avm_chipselect, avm_read_n, avm_address}, 3'b100);
    step();
    chk("poll_done", avm_chipselect, 1'b0);

    // 1: tx0 sends three bytes; one CTL_RD returns 64.
    clear_logs();
    tx0_q = '{8'h41, 8'h42, 8'h43};
    wait_rdy("t1_rdy_cnt", 3);
    chk("t1_bytes", wr_pack(0), 32'h0041_4243);
    chk("t1_ctl_cnt", ctl_cnt, 1);
    chk("t1_credit", 32'(dut.credit), 32'd61);

    // Single tx1 byte leaves rr_ptr pointing at requester 1.
    clear_logs();
    tx1_q = '{8'h30};
    wait_rdy("t1b_rdy_cnt", 1);
    chk("t1b_byte", wr_pack(0), 32'h30);
    chk("t1b_who", rdy_pack(), 32'h1);

    // 2: both requesters valid continuously -> strict alternation, 0 first.
    clear_logs();
    tx0_q = '{8'h10, 8'h11};
    tx1_q = '{8'h20, 8'h21};
    wait_rdy("t2_rdy_cnt", 4);
    chk("t2_bytes", wr_pack(0), 32'h1020_1121);
    chk("t2_who", rdy_pack(), 32'h5);
    chk("t2_credit", 32'(dut.credit), 32'd56);

    // 3: WSPACE=0 twice, then 2; third byte forces a fresh CTL_RD.
    reset_reset = 1'b1; step(); reset_reset = 1'b0;
    clear_logs();
    ctl_val = 32'h0;
    tx0_q = '{8'h50, 8'h51, 8'h52};
    for (int i = 0; i < 400 && rdy_q.size() < 3; i++) begin
      step();
      if (ctl_cnt >= 2) ctl_val = 32'h0002_0000;
    end
    chk("t3_rdy_cnt", rdy_q.size(), 3);
    chk("t3_bytes", wr_pack(0), 32'h0050_5152);
    chk("t3_ctl_at_wr", wr_pack(1), 32'h0003_0304);
    chk("t3_credit", 32'(dut.credit), 32'd1);

    // 4: stall a write for five cycles.
    clear_logs();
    tx1_q = '{8'h66};
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      found = avm_chipselect && !avm_write_n;
    end
    chk("t4_found", found, 1'b1);
    avm_waitrequest = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_cmd", {avm_chipselect, avm_write_n, avm_read_n, avm_address}, 4'b1010);
      chk("t4_hold_data", avm_writedata, 32'h66);
      chk("t4_hold_rdy", tx1_ready, 1'b0);
      if (i < 4) step();
    end
    avm_waitrequest = 1'b0;
    step();
    chk("t4_rdy_pulse", {tx1_ready, avm_chipselect}, 2'b10);
    step();
    chk("t4_rdy_drop", tx1_ready, 1'b0);
    chk("t4_one_write", wr_q.size(), 1);

    // 5: poll returns RVALID byte; nothing further read while it is held.
    clear_logs();
    dat_val = 32'h0001_8055;
    for (int i = 0; i < 100 && !rx_valid; i++) step();
    chk("t5_rx", {rx_valid, rx_data}, 9'h155);
    dat_val = 32'h0;
    drd_cnt = 0;
    for (int i = 0; i < 20; i++) step();
    chk("t5_no_poll", drd_cnt, 0);
    chk("t5_held", {rx_valid, rx_data}, 9'h155);
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    chk("t5_cleared", rx_valid, 1'b0);

    // 6: reset during a stalled write; the byte then goes out after a fresh CTL_RD.
    clear_logs();
    tx0_q = '{8'h77};
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      found = avm_chipselect && !avm_write_n;
    end
    chk("t6_found", found, 1'b1);
    avm_waitrequest = 1'b1;
    step();
    reset_reset = 1'b1;
    step();
    chk("t6_rst_cmd", {avm_chipselect, avm_write_n, avm_read_n}, 3'b011);
    chk("t6_rst_credit", 32'(dut.credit), 32'd0);
    chk("t6_rst_rdy", tx0_ready, 1'b0);
    reset_reset = 1'b0;
    avm_waitrequest = 1'b0;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      found = avm_chipselect;
    end
    chk("t6_first_cmd", {found, avm_address, avm_read_n, avm_write_n}, 4'b1101);
    wait_rdy("t6_rdy_cnt", 1);
    chk("t6_byte", wr_pack(0), 32'h77);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
